// File: rtl/clic_pkg.sv
// clic_pkg: shared types and helpers for the CLIC core-side interrupt controller.
//   clic_mode_e            - privilege mode encoding (M/S/U/reserved)
//   clic_irq_ctrl_state_e  - handshake FSM states
//   clic_thresh_sel        - one-hot select of the per-mode threshold {M,S,U}
package clic_pkg;

    typedef enum logic [1:0] {
        MODE_U    = 2'b00,
        MODE_S    = 2'b01,
        MODE_RSVD = 2'b10,
        MODE_M    = 2'b11
    } clic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OFFER = 2'b01,
        ST_KILL  = 2'b10
    } clic_irq_ctrl_state_e;

    // One-hot threshold select, bit order {mth, sth, uth}; reserved selects none.
    function automatic logic [2:0] clic_thresh_sel(input logic [1:0] mode);
        logic [2:0] sel;
        sel = 3'b000;
        case (clic_mode_e'(mode))
            MODE_M:  sel = 3'b100;
            MODE_S:  sel = 3'b010;
            MODE_U:  sel = 3'b001;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/clic_irq_elig.sv
// clic_irq_elig: combinational eligibility check of one interrupt candidate
// against the hart's privilege, interrupt level and per-mode thresholds.
//   valid_i        candidate present
//   mode_i         candidate privilege mode
//   level_i        candidate level
//   core_priv_i    current hart privilege
//   core_level_i   current interrupt level
//   mth_i/sth_i/uth_i  per-mode thresholds
//   eligible_c     candidate may be taken (combinational)
module clic_irq_elig
    import clic_pkg::*;
#(
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2
) (
    input  logic                 valid_i,
    input  logic [ModeWidth-1:0] mode_i,
    input  logic [PrioWidth-1:0] level_i,
    input  logic [ModeWidth-1:0] core_priv_i,
    input  logic [PrioWidth-1:0] core_level_i,
    input  logic [PrioWidth-1:0] mth_i,
    input  logic [PrioWidth-1:0] sth_i,
    input  logic [PrioWidth-1:0] uth_i,
    output logic                 eligible_c
);

    logic [2:0]           sel;
    logic [PrioWidth-1:0] thresh;
    logic [PrioWidth-1:0] floor_lvl;

    // Threshold of the candidate's own mode, then the higher of it and the current level.
    always_comb begin
        sel       = clic_thresh_sel(mode_i[1:0]);
        thresh    = ({PrioWidth{sel[2]}} & mth_i)
                  | ({PrioWidth{sel[1]}} & sth_i)
                  | ({PrioWidth{sel[0]}} & uth_i);
        floor_lvl = (core_level_i > thresh) ? core_level_i : thresh;
        eligible_c = valid_i
                   & (mode_i != ModeWidth'(MODE_RSVD))
                   & ((mode_i > core_priv_i)
                      | ((mode_i == core_priv_i) & (level_i > floor_lvl)));
    end

endmodule

// File: rtl/clic_irq_ctrl.sv
// clic_irq_ctrl: core-side interrupt handshake controller between the CLIC
// target (arbitration winner) and the hart.
//   clk_i, rst_ni                      clock, async active-low reset
//   tgt_valid_i/id/max/mode            winning interrupt from the target
//   tgt_ready_o                        core accepted the interrupt (combinational)
//   tgt_kill_req_i / tgt_kill_ack_o    target withdrawal request / grant (combinational ack)
//   core_priv_i, core_level_i          hart privilege and current level
//   mth_i, sth_i, uth_i                per-mode thresholds
//   irq_valid_o / irq_ready_i          registered offer to the core / core accept
//   irq_id_o, irq_level_o, irq_priv_o  latched candidate
//   irq_kill_req_o / irq_kill_ack_i    withdrawal request to the core / core grant
//   spurious_o                         pulse: core accepted after target withdrew
module clic_irq_ctrl
    import clic_pkg::*;
#(
    parameter int unsigned SrcWidth  = 8,
    parameter int unsigned PrioWidth = 8,
    parameter int unsigned ModeWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tgt_valid_i,
    output logic                 tgt_ready_o,
    input  logic [SrcWidth-1:0]  tgt_id_i,
    input  logic [PrioWidth-1:0] tgt_max_i,
    input  logic [ModeWidth-1:0] tgt_mode_i,
    input  logic                 tgt_kill_req_i,
    output logic                 tgt_kill_ack_o,
    input  logic [ModeWidth-1:0] core_priv_i,
    input  logic [PrioWidth-1:0] core_level_i,
    input  logic [PrioWidth-1:0] mth_i,
    input  logic [PrioWidth-1:0] sth_i,
    input  logic [PrioWidth-1:0] uth_i,
    output logic                 irq_valid_o,
    input  logic                 irq_ready_i,
    output logic [SrcWidth-1:0]  irq_id_o,
    output logic [PrioWidth-1:0] irq_level_o,
    output logic [ModeWidth-1:0] irq_priv_o,
    output logic                 irq_kill_req_o,
    input  logic                 irq_kill_ack_i,
    output logic                 spurious_o
);

    clic_irq_ctrl_state_e state_q;
    logic                 live_elig_c;
    logic                 held_elig_c;
    logic                 kill_cond_c;

    // Live candidate from the target.
    clic_irq_elig #(.PrioWidth(PrioWidth), .ModeWidth(ModeWidth)) u_elig_live (
        .valid_i      (tgt_valid_i),
        .mode_i       (tgt_mode_i),
        .level_i      (tgt_max_i),
        .core_priv_i  (core_priv_i),
        .core_level_i (core_level_i),
        .mth_i        (mth_i),
        .sth_i        (sth_i),
        .uth_i        (uth_i),
        .eligible_c   (live_elig_c)
    );

    // Latched candidate, re-checked every cycle against the live hart state.
    clic_irq_elig #(.PrioWidth(PrioWidth), .ModeWidth(ModeWidth)) u_elig_held (
        .valid_i      (1'b1),
        .mode_i       (irq_priv_o),
        .level_i      (irq_level_o),
        .core_priv_i  (core_priv_i),
        .core_level_i (core_level_i),
        .mth_i        (mth_i),
        .sth_i        (sth_i),
        .uth_i        (uth_i),
        .eligible_c   (held_elig_c)
    );

    assign kill_cond_c = tgt_kill_req_i | ~tgt_valid_i | ~held_elig_c;

    // Handshake FSM; offer/kill/spurious outputs are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b0;
            irq_id_o       <= '0;
            irq_level_o    <= '0;
            irq_priv_o     <= '0;
            spurious_o     <= 1'b0;
        end else begin
            spurious_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (live_elig_c) begin
                        state_q     <= ST_OFFER;
                        irq_valid_o <= 1'b1;
                        irq_id_o    <= tgt_id_i;
                        irq_level_o <= tgt_max_i;
                        irq_priv_o  <= tgt_mode_i;
                    end
                end
                ST_OFFER: begin
                    if (irq_ready_i) begin
                        state_q     <= ST_IDLE;
                        irq_valid_o <= 1'b0;
                    end else if (kill_cond_c) begin
                        state_q        <= ST_KILL;
                        irq_kill_req_o <= 1'b1;
                    end
                end
                ST_KILL: begin
                    if (irq_ready_i || irq_kill_ack_i) begin
                        state_q        <= ST_IDLE;
                        irq_valid_o    <= 1'b0;
                        irq_kill_req_o <= 1'b0;
                        // Core took an interrupt the target no longer offers.
                        spurious_o     <= irq_ready_i & ~tgt_valid_i;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    irq_valid_o    <= 1'b0;
                    irq_kill_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Target-side acknowledges; a core accept always takes precedence over a kill grant.
    always_comb begin
        tgt_ready_o    = 1'b0;
        tgt_kill_ack_o = 1'b0;
        case (state_q)
            ST_IDLE:  tgt_kill_ack_o = tgt_kill_req_i;
            ST_OFFER: tgt_ready_o    = irq_ready_i;
            ST_KILL: begin
                if (irq_ready_i) begin
                    tgt_ready_o = tgt_valid_i;
                end else if (irq_kill_ack_i) begin
                    tgt_kill_ack_o = tgt_kill_req_i;
                end
            end
            default: ;
        endcase
        // Nothing is acknowledged while held in reset.
        if (!rst_ni) begin
            tgt_ready_o    = 1'b0;
            tgt_kill_ack_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_clic_irq_ctrl.sv
// tb_clic_irq_ctrl: directed self-checking bench for clic_irq_ctrl.
module tb_clic_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tgt_valid_i;
    logic       tgt_ready_o;
    logic [7:0] tgt_id_i;
    logic [7:0] tgt_max_i;
    logic [1:0] tgt_mode_i;
    logic       tgt_kill_req_i;
    logic       tgt_kill_ack_o;
    logic [1:0] core_priv_i;
    logic [7:0] core_level_i;
    logic [7:0] mth_i, sth_i, uth_i;
    logic       irq_valid_o;
    logic       irq_ready_i;
    logic [7:0] irq_id_o;
    logic [7:0] irq_level_o;
    logic [1:0] irq_priv_o;
    logic       irq_kill_req_o;
    logic       irq_kill_ack_i;
    logic       spurious_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    clic_irq_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tgt_valid_i    (tgt_valid_i),
        .tgt_ready_o    (tgt_ready_o),
        .tgt_id_i       (tgt_id_i),
        .tgt_max_i      (tgt_max_i),
        .tgt_mode_i     (tgt_mode_i),
        .tgt_kill_req_i (tgt_kill_req_i),
        .tgt_kill_ack_o (tgt_kill_ack_o),
        .core_priv_i    (core_priv_i),
        .core_level_i   (core_level_i),
        .mth_i          (mth_i),
        .sth_i          (sth_i),
        .uth_i          (uth_i),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_id_o       (irq_id_o),
        .irq_level_o    (irq_level_o),
        .irq_priv_o     (irq_priv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i),
        .spurious_o     (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable until the following one.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        tgt_valid_i    = 1'b0;
        tgt_id_i       = 8'd0;
        tgt_max_i      = 8'd0;
        tgt_mode_i     = 2'b00;
        tgt_kill_req_i = 1'b0;
        core_priv_i    = 2'b00;
        core_level_i   = 8'd0;
        mth_i          = 8'd0;
        sth_i          = 8'd0;
        uth_i          = 8'd0;
        irq_ready_i    = 1'b0;
        irq_kill_ack_i = 1'b0;

        // Reset state
        #12;
        chk("rst_valid",    32'(irq_valid_o),    32'd0);
        chk("rst_killreq",  32'(irq_kill_req_o), 32'd0);
        chk("rst_id",       32'(irq_id_o),       32'd0);
        chk("rst_spurious", 32'(spurious_o),     32'd0);
        chk("rst_tready",   32'(tgt_ready_o),    32'd0);
        chk("rst_tkack",    32'(tgt_kill_ack_o), 32'd0);
        rst_ni = 1'b1;
        step();

        // Basic accept: U mode, level 0, uth 0, id 5 max 3
        tgt_valid_i = 1'b1; tgt_id_i = 8'd5; tgt_max_i = 8'd3; tgt_mode_i = 2'b00;
        #1;
        chk("basic_pre_valid", 32'(irq_valid_o), 32'd0);
        step();
        chk("basic_valid", 32'(irq_valid_o), 32'd1);
        chk("basic_id",    32'(irq_id_o),    32'd5);
        chk("basic_level", 32'(irq_level_o), 32'd3);
        chk("basic_priv",  32'(irq_priv_o),  32'd0);
        chk("basic_tready_low", 32'(tgt_ready_o), 32'd0);
        irq_ready_i = 1'b1;
        #1;
        chk("basic_tready", 32'(tgt_ready_o),    32'd1);
        chk("basic_tkack",  32'(tgt_kill_ack_o), 32'd0);
        step();
        irq_ready_i = 1'b0; tgt_valid_i = 1'b0;
        chk("basic_idle_valid", 32'(irq_valid_o), 32'd0);
        step();

        // Threshold block: M mode, mth 8, max 8 -> 8 > max(0,8) false
        core_priv_i = 2'b11; mth_i = 8'd8;
        tgt_valid_i = 1'b1; tgt_id_i = 8'd9; tgt_max_i = 8'd8; tgt_mode_i = 2'b11;
        step();
        chk("thr_block1", 32'(irq_valid_o), 32'd0);
        step();
        chk("thr_block2", 32'(irq_valid_o), 32'd0);
        mth_i = 8'd7;
        step();
        chk("thr_open_valid", 32'(irq_valid_o), 32'd1);
        chk("thr_open_id",    32'(irq_id_o),    32'd9);
        chk("thr_open_priv",  32'(irq_priv_o),  32'd3);

        // Target kill from OFFER
        tgt_kill_req_i = 1'b1;
        #1;
        chk("tkill_offer_noack", 32'(tgt_kill_ack_o), 32'd0);
        step();
        chk("tkill_killreq", 32'(irq_kill_req_o), 32'd1);
        chk("tkill_valid",   32'(irq_valid_o),    32'd1);
        chk("tkill_noack_wait", 32'(tgt_kill_ack_o), 32'd0);
        irq_kill_ack_i = 1'b1;
        #1;
        chk("tkill_ack",     32'(tgt_kill_ack_o), 32'd1);
        chk("tkill_tready",  32'(tgt_ready_o),    32'd0);
        step();
        irq_kill_ack_i = 1'b0; tgt_kill_req_i = 1'b0; tgt_valid_i = 1'b0;
        chk("tkill_idle_valid",   32'(irq_valid_o),    32'd0);
        chk("tkill_idle_killreq", 32'(irq_kill_req_o), 32'd0);
        // Kill requests in IDLE are granted immediately
        tgt_kill_req_i = 1'b1;
        #1;
        chk("idle_kill_ack", 32'(tgt_kill_ack_o), 32'd1);
        tgt_kill_req_i = 1'b0;
        step();

        // Race: ready and kill ack together in KILL -> ready wins
        tgt_valid_i = 1'b1; tgt_id_i = 8'd17;
        step();
        chk("race_offer", 32'(irq_valid_o), 32'd1);
        tgt_kill_req_i = 1'b1;
        step();
        chk("race_kill", 32'(irq_kill_req_o), 32'd1);
        irq_ready_i = 1'b1; irq_kill_ack_i = 1'b1;
        #1;
        chk("race_tready", 32'(tgt_ready_o),    32'd1);
        chk("race_tkack",  32'(tgt_kill_ack_o), 32'd0);
        step();
        irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0; tgt_kill_req_i = 1'b0; tgt_valid_i = 1'b0;
        chk("race_idle",     32'(irq_valid_o), 32'd0);
        chk("race_spurious", 32'(spurious_o),  32'd0);
        step();

        // Eligibility loss: core level rises to 8 while offering max 8
        tgt_valid_i = 1'b1; tgt_id_i = 8'd18;
        step();
        chk("elig_offer", 32'(irq_valid_o), 32'd1);
        core_level_i = 8'd8;
        step();
        chk("elig_killreq", 32'(irq_kill_req_o), 32'd1);
        irq_kill_ack_i = 1'b1;
        #1;
        chk("elig_tkack_noreq", 32'(tgt_kill_ack_o), 32'd0);
        chk("elig_tready",      32'(tgt_ready_o),    32'd0);
        step();
        irq_kill_ack_i = 1'b0; tgt_valid_i = 1'b0; core_level_i = 8'd0;
        chk("elig_idle", 32'(irq_valid_o), 32'd0);
        step();

        // Level source cleared: tgt_valid drops in OFFER, core accepts in KILL
        tgt_valid_i = 1'b1; tgt_id_i = 8'h22;
        step();
        chk("lvl_offer_id", 32'(irq_id_o), 32'h22);
        tgt_valid_i = 1'b0;
        step();
        chk("lvl_kill", 32'(irq_kill_req_o), 32'd1);
        chk("lvl_id_held", 32'(irq_id_o), 32'h22);
        irq_ready_i = 1'b1;
        #1;
        chk("lvl_tready", 32'(tgt_ready_o), 32'd0);
        step();
        irq_ready_i = 1'b0;
        chk("lvl_spurious", 32'(spurious_o),  32'd1);
        chk("lvl_idle",     32'(irq_valid_o), 32'd0);
        step();
        chk("lvl_spurious_end", 32'(spurious_o), 32'd0);

        // Reset asserted in OFFER
        tgt_valid_i = 1'b1; tgt_id_i = 8'h33;
        step();
        chk("rstoffer_valid", 32'(irq_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0; irq_ready_i = 1'b1;
        #1;
        chk("rstoffer_valid0",  32'(irq_valid_o),    32'd0);
        chk("rstoffer_kill0",   32'(irq_kill_req_o), 32'd0);
        chk("rstoffer_id0",     32'(irq_id_o),       32'd0);
        chk("rstoffer_level0",  32'(irq_level_o),    32'd0);
        chk("rstoffer_priv0",   32'(irq_priv_o),     32'd0);
        chk("rstoffer_tready0", 32'(tgt_ready_o),    32'd0);
        chk("rstoffer_tkack0",  32'(tgt_kill_ack_o), 32'd0);
        tgt_valid_i = 1'b0; irq_ready_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        step();
        chk("rstoffer_post_idle", 32'(irq_valid_o), 32'd0);
        tgt_valid_i = 1'b1;
        step();
        chk("rstoffer_reoffer", 32'(irq_valid_o), 32'd1);
        chk("rstoffer_reid",    32'(irq_id_o),    32'h33);
        tgt_valid_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
